// File: rtl/mem_arbiter.sv
// Shares one multicycle memory between the I-cache fill path and the D-cache
// (block fills plus single-word write-through), tagging returned words by index.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int WORDS       = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [15:0]              d_wdata,
  output logic                     i_grant,
  output logic                     d_grant,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_idx,
  output logic                     i_word_valid,
  output logic                     d_word_valid,
  output logic                     i_done,
  output logic                     d_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [15:0]              mem_data_in,
  input  logic [15:0]              mem_data_out,
  input  logic                     mem_data_valid
);
  localparam int IW  = $clog2(WORDS);
  localparam int OFS = IW + 1;

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t                 r_state, w_next;
  logic [IW-1:0]          r_iss, r_rcv;
  logic                   r_iss_done, r_last_d, r_i_grant, r_d_grant;
  logic [ADDR_W-OFS-1:0]  r_blk;
  logic                   w_fill, w_vld, w_last;
  logic                   w_unused;

  // Byte/word offset of the I-side address never reaches memory.
  assign w_unused = ^i_addr[OFS-1:0];

  always_comb begin
    w_next      = r_state;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    w_fill      = (r_state == I_FILL) || (r_state == D_FILL);
    w_vld       = w_fill && mem_data_valid;
    w_last      = w_vld && (r_rcv == IW'(WORDS - 1));
    case (r_state)
      IDLE: begin
        // last_d hands a contested slot to I right after any D transaction.
        if (d_req && !(i_req && r_last_d)) w_next = d_wr ? D_WRITE : D_FILL;
        else if (i_req)                    w_next = I_FILL;
      end
      I_FILL, D_FILL: begin
        mem_enable = !r_iss_done;
        mem_addr   = r_iss_done ? '0 : {r_blk, r_iss, 1'b0};
        if (w_last) w_next = IDLE;
      end
      D_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_addr;
        mem_data_in = d_wdata;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
    fill_data    = w_vld ? mem_data_out : '0;
    fill_idx     = w_vld ? r_rcv : '0;
    i_word_valid = w_vld && (r_state == I_FILL);
    d_word_valid = w_vld && (r_state == D_FILL);
    i_done       = w_last && (r_state == I_FILL);
    d_done       = (r_state == D_WRITE) || (w_last && (r_state == D_FILL));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_iss      <= '0;
      r_rcv      <= '0;
      r_iss_done <= 1'b0;
      r_last_d   <= 1'b0;
      r_i_grant  <= 1'b0;
      r_d_grant  <= 1'b0;
      r_blk      <= '0;
    end else begin
      r_state   <= w_next;
      r_i_grant <= (w_next == I_FILL);
      r_d_grant <= (w_next == D_FILL) || (w_next == D_WRITE);
      if (r_state == IDLE) begin
        r_iss      <= '0;
        r_rcv      <= '0;
        r_iss_done <= 1'b0;
        r_blk      <= (w_next == I_FILL) ? i_addr[ADDR_W-1:OFS] : d_addr[ADDR_W-1:OFS];
      end else if (w_fill) begin
        // Counters saturate in-state; only re-entry clears them.
        if (!r_iss_done) begin
          if (r_iss == IW'(WORDS - 1)) r_iss_done <= 1'b1;
          else                         r_iss      <= r_iss + 1'b1;
        end
        if (w_vld && !w_last) r_rcv <= r_rcv + 1'b1;
      end
      if (r_state != IDLE && w_next == IDLE) r_last_d <= (r_state != I_FILL);
    end
  end

  assign i_grant = r_i_grant;
  assign d_grant = r_d_grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-4 memory model, per-cycle reference model
// compare, and directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int WORDS = 8;
  localparam int M_IDLE = 0, M_I = 1, M_D = 2, M_W = 3;

  logic        clk, rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_word_valid, d_word_valid, i_done, d_done;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic [2:0]  fill_idx;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic        stray;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LATENCY(LAT), .WORDS(WORDS), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_word_valid(i_word_valid), .d_word_valid(d_word_valid),
    .i_done(i_done), .d_done(d_done),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data = addr ^ 5A5A, valid LAT cycles after issue, flushed by rst_n.
  logic [LAT-1:0] p_v;
  logic [15:0]    p_d [LAT];
  always @(posedge clk) begin
    if (!rst_n) p_v <= '0;
    else        p_v <= {p_v[LAT-2:0], mem_enable && !mem_wr};
    p_d[0] <= mem_addr ^ 16'h5A5A;
    for (int i = 1; i < LAT; i++) p_d[i] <= p_d[i-1];
  end
  assign mem_data_valid = p_v[LAT-1] | stray;
  assign mem_data_out   = stray ? 16'hC0DE : p_d[LAT-1];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: owner, words issued, words received, block, fairness bit.
  int          m_own = M_IDLE, m_iss = 0, m_rcv = 0;
  logic [15:0] m_blk = 16'h0;
  bit          m_last_d = 1'b0, m_ok = 1'b0;

  always @(negedge clk) begin : model
    bit fl, vl, iss_on;
    logic [15:0] ea;
    fl     = (m_own == M_I) || (m_own == M_D);
    vl     = fl && mem_data_valid;
    iss_on = fl && (m_iss < WORDS);
    ea     = (m_own == M_W) ? d_addr :
             iss_on ? ({m_blk[15:4], 4'h0} + 16'(2 * m_iss)) : 16'h0;
    if (m_ok) begin
      chk("i_grant",      32'(i_grant),      32'(m_own == M_I));
      chk("d_grant",      32'(d_grant),      32'(m_own == M_D || m_own == M_W));
      chk("mem_enable",   32'(mem_enable),   32'(iss_on || m_own == M_W));
      chk("mem_wr",       32'(mem_wr),       32'(m_own == M_W));
      chk("mem_addr",     32'(mem_addr),     32'(ea));
      chk("mem_data_in",  32'(mem_data_in),  32'((m_own == M_W) ? d_wdata : 16'h0));
      chk("i_word_valid", 32'(i_word_valid), 32'(vl && m_own == M_I));
      chk("d_word_valid", 32'(d_word_valid), 32'(vl && m_own == M_D));
      chk("fill_data",    32'(fill_data),    32'(vl ? mem_data_out : 16'h0));
      chk("fill_idx",     32'(fill_idx),     vl ? 32'(m_rcv) : 32'd0);
      chk("i_done",       32'(i_done),       32'(vl && m_own == M_I && m_rcv == WORDS-1));
      chk("d_done",       32'(d_done),       32'((vl && m_own == M_D && m_rcv == WORDS-1) || m_own == M_W));
    end
    if (!rst_n) begin
      m_own = M_IDLE; m_last_d = 1'b0; m_ok = 1'b1;
    end else if (m_own == M_IDLE) begin
      if (d_req && i_req) m_own = m_last_d ? M_I : (d_wr ? M_W : M_D);
      else if (d_req)     m_own = d_wr ? M_W : M_D;
      else if (i_req)     m_own = M_I;
      m_blk = (m_own == M_I) ? i_addr : d_addr;
      m_iss = 0; m_rcv = 0;
    end else if (m_own == M_W) begin
      m_own = M_IDLE; m_last_d = 1'b1;
    end else begin
      if (m_iss < WORDS) m_iss++;
      if (vl) begin
        if (m_rcv == WORDS-1) begin
          m_last_d = (m_own == M_D); m_own = M_IDLE;
        end else m_rcv++;
      end
    end
  end

  // Per-scenario tallies, written only by the stimulus process.
  int          n_iwv, n_dwv, n_idone, n_ddone, n_igr, n_dgr, first_own;
  logic [15:0] addrq[$], fdq[$], w_addr, w_data;
  int          idxq[$];

  task automatic clear();
    n_iwv = 0; n_dwv = 0; n_idone = 0; n_ddone = 0; n_igr = 0; n_dgr = 0;
    first_own = 0; addrq.delete(); fdq.delete(); idxq.delete();
    w_addr = 16'h0; w_data = 16'h0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_enable && !mem_wr) addrq.push_back(mem_addr);
    if (mem_wr) begin w_addr = mem_addr; w_data = mem_data_in; end
    if (i_word_valid) begin n_iwv++; idxq.push_back(int'(fill_idx)); fdq.push_back(fill_data); end
    if (d_word_valid) begin n_dwv++; idxq.push_back(int'(fill_idx)); end
    if (i_done) n_idone++;
    if (d_done) n_ddone++;
    if (i_grant) n_igr++;
    if (d_grant) n_dgr++;
    if (first_own == 0) first_own = d_grant ? 2 : (i_grant ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit is_i, input int budget, output int cyc);
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      cyc = c;
      if ((is_i ? n_idone : n_ddone) > 0) break;
    end
    chk(is_i ? "i_done_timeout" : "d_done_timeout", 32'(is_i ? n_idone : n_ddone), 32'd1);
  endtask

  task automatic chk_addrs(input string nm, input logic [15:0] base);
    chk({nm, "_count"}, 32'(addrq.size()), 32'd8);
    for (int k = 0; k < 8 && k < addrq.size(); k++)
      chk(nm, 32'(addrq[k]), 32'(base + 16'(2 * k)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; stray = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    do_reset();
    chk("rst_i_grant", 32'(i_grant), 32'd0);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);

    // I-only fill at 0x1236
    clear();
    i_req = 1'b1; i_addr = 16'h1236;
    wait_done(1'b1, 30, cyc);
    i_req = 1'b0;
    chk("t1_cycles", 32'(cyc), 32'd13);
    chk("t1_grant_len", 32'(n_igr), 32'd12);
    chk("t1_iwv", 32'(n_iwv), 32'd8);
    chk("t1_dwv", 32'(n_dwv + n_dgr + n_ddone), 32'd0);
    chk_addrs("t1_addr", 16'h1230);
    for (int k = 0; k < 8 && k < idxq.size(); k++) chk("t1_idx", 32'(idxq[k]), 32'(k));
    if (fdq.size() > 0) chk("t1_first_data", 32'(fdq[0]), 32'h486A);
    tick();

    // Single D write
    clear();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h4002; d_wdata = 16'hBEEF;
    tick();
    chk("t2_mem_wr", 32'(mem_wr), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h4002);
    chk("t2_mem_data_in", 32'(mem_data_in), 32'hBEEF);
    chk("t2_d_done", 32'(d_done), 32'd1);
    chk("t2_d_grant", 32'(d_grant), 32'd1);
    d_req = 1'b0; d_wr = 1'b0;
    tick();
    chk("t2_idle_grant", 32'(d_grant), 32'd0);
    chk("t2_idle_wr", 32'(mem_wr), 32'd0);

    // Contention from reset: D first, then I; after a D write, I wins
    do_reset();
    clear();
    i_req = 1'b1; i_addr = 16'h0080; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    wait_done(1'b0, 30, cyc);
    d_req = 1'b0;
    chk("t3_first_d", 32'(first_own), 32'd2);
    chk("t3_no_i_yet", 32'(n_igr), 32'd0);
    chk_addrs("t3_d_addr", 16'h0040);
    clear();
    wait_done(1'b1, 30, cyc);
    i_req = 1'b0;
    chk("t3_i_cycles", 32'(cyc), 32'd13);
    chk_addrs("t3_i_addr", 16'h0080);
    clear();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0102; d_wdata = 16'h1111;
    wait_done(1'b0, 10, cyc);
    d_req = 1'b0;
    tick();
    clear();
    i_req = 1'b1; i_addr = 16'h0200; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'h2222;
    wait_done(1'b1, 30, cyc);
    i_req = 1'b0;
    chk("t3_fair_first_i", 32'(first_own), 32'd1);
    clear();
    wait_done(1'b0, 10, cyc);
    d_req = 1'b0; d_wr = 1'b0;
    chk("t3_w_cycles", 32'(cyc), 32'd2);
    chk("t3_w_addr", 32'(w_addr), 32'h0300);
    chk("t3_w_data", 32'(w_data), 32'h2222);
    tick();

    // D fill with request dropped at issue k=3
    clear();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
    repeat (4) tick();
    d_req = 1'b0;
    wait_done(1'b0, 30, cyc);
    repeat (5) tick();
    chk_addrs("t4_addr", 16'h0300);
    chk("t4_dwv", 32'(n_dwv), 32'd8);
    chk("t4_ddone", 32'(n_ddone), 32'd1);
    chk("t4_grant_len", 32'(n_dgr), 32'd12);

    // Reset at receive index 5 of an I fill
    clear();
    i_req = 1'b1; i_addr = 16'h2000;
    for (int c = 0; c < 30 && n_iwv < 5; c++) tick();
    chk("t5_reach5", 32'(n_iwv), 32'd5);
    chk("t5_idx5_now", 32'(fill_idx), 32'd5);
    rst_n = 1'b0; i_req = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_grant", 32'(i_grant), 32'd0);
    chk("t5_enable", 32'(mem_enable), 32'd0);
    chk("t5_idone", 32'(i_done), 32'd0);
    chk("t5_fill_idx", 32'(fill_idx), 32'd0);
    clear();
    stray = 1'b1;
    #1;
    chk("t5_stray_iwv", 32'(i_word_valid), 32'd0);
    chk("t5_stray_data", 32'(fill_data), 32'd0);
    tick();
    stray = 1'b0;
    chk("t5_stray_count", 32'(n_iwv + n_dwv), 32'd0);
    clear();
    i_req = 1'b1; i_addr = 16'h2000;
    wait_done(1'b1, 30, cyc);
    i_req = 1'b0;
    chk("t5_refill_iwv", 32'(n_iwv), 32'd8);
    for (int k = 0; k < 8 && k < idxq.size(); k++) chk("t5_refill_idx", 32'(idxq[k]), 32'(k));
    tick();

    // D fill with d_addr corrupted mid-transaction
    clear();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    repeat (3) tick();
    d_addr = 16'hFFFF;
    wait_done(1'b0, 30, cyc);
    d_req = 1'b0;
    chk_addrs("t6_addr", 16'h0010);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
